cordic_atan2: RTL

Pipelined CORDIC vectoring engine that converts a signed I/Q sample pair into a phase word and an uncompensated magnitude. It is the inverse of the team's sin/cos generator: its phase output uses the same convention, with 0..2^PHASE_W-1 mapping to 0..2π. Feeding it (cos, sin) of phase p returns p. It sits behind mixers and NCOs in the receive path for phase/frequency detection and carrier-recovery loops. It has a fully pipelined datapath that accepts one sample per clock with no backpressure.

---
 rtl/cordic_atan2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cordic_atan2.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_atan2
//  Brief    : Pipelined CORDIC vectoring engine, signed I/Q -> phase + K*|v|.
//  Revision : 1.0 - initial release
// ============================================================================
module cordic_atan2 #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 12,
    parameter int N_ITER  = 14,
    parameter int G_W     = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_i,
    input  logic [DATA_W-1:0]  i_q,
    output logic               o_valid,
    output logic [PHASE_W-1:0] o_phase,
    output logic [DATA_W:0]    o_mag
);

    localparam int XW = DATA_W + 2;
    localparam int ZW = PHASE_W + G_W;

    localparam logic [ZW-1:0] C_QUARTER    = {2'b01, {(ZW-2){1'b0}}};
    localparam logic [ZW-1:0] C_3QUARTER   = {2'b11, {(ZW-2){1'b0}}};
    localparam logic [ZW-1:0] C_HALF_LSB   = ZW'(2 ** (G_W - 1));

    // atan(2^-k) scaled so that 2^ZW is a full turn; series form keeps the
    // elaboration free of math-library calls.
    function automatic logic [ZW-1:0] atan_angle(input int k);
        real t;
        real term;
        real sum;
        real full;
        t = 1.0;
        for (int j = 0; j < k; j++) begin
            t = t / 2.0;
        end
        if (k == 0) begin
            sum = 3.14159265358979323846 / 4.0;
        end else begin
            sum  = 0.0;
            term = t;
            for (int n = 0; n < 40; n++) begin
                sum  = sum + term / real'(2 * n + 1);
                term = -term * t * t;
            end
        end
        full = real'(2 ** ZW);
        return ZW'($rtoi(sum * full / (2.0 * 3.14159265358979323846) + 0.5));
    endfunction

    logic [ZW-1:0] atan_tbl [N_ITER];

    for (genvar k = 0; k < N_ITER; k++) begin : g_atan
        localparam logic [ZW-1:0] C_ANGLE = atan_angle(k);
        assign atan_tbl[k] = C_ANGLE;
    end

    logic signed [XW-1:0] i_ext;
    logic signed [XW-1:0] q_ext;
    logic                 zero_in;

    assign i_ext   = {{2{i_i[DATA_W-1]}}, i_i};
    assign q_ext   = {{2{i_q[DATA_W-1]}}, i_q};
    assign zero_in = (i_i == '0) && (i_q == '0);

    logic signed [XW-1:0] x_q [0:N_ITER];
    logic signed [XW-1:0] x_d [0:N_ITER];
    logic signed [XW-1:0] y_q [0:N_ITER-1];
    logic signed [XW-1:0] y_d [0:N_ITER-1];
    logic [ZW-1:0]        z_q [0:N_ITER];
    logic [ZW-1:0]        z_d [0:N_ITER];
    logic [N_ITER:0]      vld_q;
    logic [N_ITER:0]      zero_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;

        // Fold the left half-plane onto the right by a +/-90 degree turn.
        if (!i_i[DATA_W-1]) begin
            x_d[0] = i_ext;
            y_d[0] = q_ext;
            z_d[0] = '0;
        end else if (!i_q[DATA_W-1]) begin
            x_d[0] = q_ext;
            y_d[0] = -i_ext;
            z_d[0] = C_QUARTER;
        end else begin
            x_d[0] = -q_ext;
            y_d[0] = i_ext;
            z_d[0] = C_3QUARTER;
        end

        for (int k = 0; k < N_ITER - 1; k++) begin
            if (!y_q[k][XW-1]) begin
                x_d[k+1] = x_q[k] + (y_q[k] >>> k);
                y_d[k+1] = y_q[k] - (x_q[k] >>> k);
                z_d[k+1] = z_q[k] + atan_tbl[k];
            end else begin
                x_d[k+1] = x_q[k] - (y_q[k] >>> k);
                y_d[k+1] = y_q[k] + (x_q[k] >>> k);
                z_d[k+1] = z_q[k] - atan_tbl[k];
            end
        end

        // The last micro-rotation only needs x and z; y is never consumed.
        if (!y_q[N_ITER-1][XW-1]) begin
            x_d[N_ITER] = x_q[N_ITER-1] + (y_q[N_ITER-1] >>> (N_ITER - 1));
            z_d[N_ITER] = z_q[N_ITER-1] + atan_tbl[N_ITER-1];
        end else begin
            x_d[N_ITER] = x_q[N_ITER-1] - (y_q[N_ITER-1] >>> (N_ITER - 1));
            z_d[N_ITER] = z_q[N_ITER-1] - atan_tbl[N_ITER-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[N_ITER-1:0], i_valid};
        end
        zero_q <= {zero_q[N_ITER-1:0], zero_in};
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
    end

    logic [ZW-1:0]      z_rnd;
    logic               valid_q;
    logic [PHASE_W-1:0] phase_q;
    logic [DATA_W:0]    mag_q;

    assign z_rnd = z_q[N_ITER] + C_HALF_LSB;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            phase_q <= '0;
            mag_q   <= '0;
        end else begin
            valid_q <= vld_q[N_ITER];
            if (zero_q[N_ITER]) begin
                phase_q <= '0;
                mag_q   <= '0;
            end else begin
                phase_q <= z_rnd[ZW-1:G_W];
                mag_q   <= x_q[N_ITER][DATA_W:0];
            end
        end
    end

    assign o_valid = valid_q;
    assign o_phase = phase_q;
    assign o_mag   = mag_q;

    // Final x is never negative and the rounded-away z bits carry no phase.
    logic unused_bits;
    assign unused_bits = ^{x_q[N_ITER][XW-1], z_rnd[G_W-1:0]};

endmodule
`default_nettype wire
